// File: rtl/led_pkg.sv
// Shared definitions for the LED bar driver: mode encodings and a counter-width helper.
package led_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_BAR   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_DOT   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_DRAIN = 3'd3;
    localparam logic [MODE_W-1:0] MODE_SWEEP = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ALL   = 3'd5;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Enabled wrap-around counter; tick pulses for one cycle on the edge where the count wraps.
module led_prescaler
    import led_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_bar_driver.sv
// Registered LED bar driver: level/mode to N-bit pattern, bouncing-dot sweep and blink gating.
module led_bar_driver
    import led_pkg::*;
#(
    parameter int N_LEDS    = 5,
    parameter int LVL_W     = 3,
    parameter int BLINK_DIV = 25000000,
    parameter int SWEEP_DIV = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode,
    input  logic [LVL_W-1:0]  level,
    input  logic              level_valid,
    input  logic              blink_en,
    output logic [N_LEDS-1:0] out
);

    localparam int            PW        = clog2(N_LEDS);
    localparam logic [PW-1:0] POS_TOP   = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] POS_BELOW = (N_LEDS > 1) ? PW'(N_LEDS - 2) : '0;
    localparam logic [PW-1:0] POS_ONE   = (N_LEDS > 1) ? PW'(1) : '0;

    logic [N_LEDS-1:0] out_q, out_d;
    logic [LVL_W-1:0]  level_reg_q;
    logic [MODE_W-1:0] mode_q;
    logic [PW-1:0]     pos_q, pos_d;
    logic              dir_q, dir_d;   // 0 = up, 1 = down
    logic              phase_q, phase_d;
    logic              sweep_active, sweep_restart, sweep_tick, blink_tick;
    logic              blink_on;
    logic [LVL_W-1:0]  level_eff;

    function automatic logic [N_LEDS-1:0] pattern(input logic [MODE_W-1:0] m,
                                                  input logic [LVL_W-1:0]  l,
                                                  input logic [PW-1:0]     p);
        logic [N_LEDS-1:0] r;
        int                lv;
        r  = '0;
        lv = int'(l);
        for (int i = 0; i < N_LEDS; i++) begin
            case (m)
                MODE_BAR:   r[i] = (i <= lv);
                MODE_DOT:   r[i] = (lv >= N_LEDS - 1) ? (i == 0) : (i == N_LEDS - 1 - lv);
                MODE_DRAIN: begin
                    if (lv == 0)               r[i] = 1'b1;
                    else if (lv <= N_LEDS - 2) r[i] = (i == N_LEDS - 1) || (i < N_LEDS - 1 - lv);
                    else                       r[i] = 1'b0;
                end
                MODE_SWEEP: r[i] = (i == int'(p));
                MODE_ALL:   r[i] = 1'b1;
                default:    r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    assign level_eff     = level_valid ? level : level_reg_q;
    assign sweep_active  = (mode == MODE_SWEEP);
    assign sweep_restart = sweep_active && (mode_q != MODE_SWEEP);
    assign blink_on      = blink_en ? phase_q : 1'b1;
    assign out           = out_q;

    led_prescaler #(.DIV(SWEEP_DIV)) u_sweep_div (
        .clk  (clk),
        .rst  (rst),
        .en   (sweep_active),
        .clr  (sweep_restart),
        .tick (sweep_tick)
    );

    led_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .en   (blink_en),
        .clr  (!blink_en),
        .tick (blink_tick)
    );

    // Bouncing dot: 0,1,..,N-1,N-2,..,0,1,...
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (sweep_restart) begin
            pos_d = '0;
            dir_d = 1'b0;
        end else if (sweep_tick && N_LEDS > 1) begin
            if (!dir_q) begin
                if (pos_q == POS_TOP) begin
                    dir_d = 1'b1;
                    pos_d = POS_BELOW;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end else begin
                if (pos_q == '0) begin
                    dir_d = 1'b0;
                    pos_d = POS_ONE;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        phase_d = 1'b1;
        if (blink_en) begin
            phase_d = blink_tick ? ~phase_q : phase_q;
        end
    end

    // The sweep dot shown is the position after this edge, so a step is visible immediately.
    always_comb begin
        out_d = out_q;
        if (mode <= MODE_ALL) begin
            out_d = pattern(mode, level_eff, pos_d) & {N_LEDS{blink_on}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q       <= '1;
            level_reg_q <= '0;
            mode_q      <= MODE_OFF;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            phase_q     <= 1'b1;
        end else begin
            out_q   <= out_d;
            mode_q  <= mode;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            if (level_valid) begin
                level_reg_q <= level;
            end
        end
    end

endmodule

// File: tb/tb_led_bar_driver.sv
// Scoreboard bench for led_bar_driver: directed plan sequences plus randomized traffic vs a reference model.
module tb_led_bar_driver;

    localparam int N  = 5;
    localparam int BD = 4;
    localparam int SD = 2;
    localparam int FULL = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [2:0]   level = 3'd0;
    logic         level_valid = 1'b0;
    logic         blink_en = 1'b0;
    logic [N-1:0] dout;

    always #5 clk = ~clk;

    led_bar_driver #(
        .N_LEDS    (N),
        .LVL_W     (3),
        .BLINK_DIV (BD),
        .SWEEP_DIV (SD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .level       (level),
        .level_valid (level_valid),
        .blink_en    (blink_en),
        .out         (dout)
    );

    typedef struct {
        int exp;
        int seq;
    } sb_item_t;

    sb_item_t sb[$];
    int       checks = 0;
    int       errors = 0;
    int       seq_no = 0;
    string    tag = "reset";

    // Reference model state, kept in plain integers.
    int m_level = 0;
    int m_prev_mode = 0;
    int m_prev_blink = 0;
    int m_sweep_k = 0;
    int m_blink_k = 0;
    int m_out = FULL;

    function automatic int tri_pos(input int steps);
        int k;
        if (N == 1) return 0;
        k = steps % (2 * (N - 1));
        return (k < N) ? k : 2 * (N - 1) - k;
    endfunction

    function automatic int pat(input int m, input int l, input int pos);
        int n;
        case (m)
            1: begin
                n = (l + 1 < N) ? l + 1 : N;
                return (1 << n) - 1;
            end
            2: return (l >= N - 1) ? 1 : (1 << (N - 1 - l));
            3: begin
                if (l == 0) return FULL;
                if (l <= N - 2) return (1 << (N - 1)) | ((1 << (N - 1 - l)) - 1);
                return 0;
            end
            4: return 1 << pos;
            5: return FULL;
            default: return 0;
        endcase
    endfunction

    function automatic void model_edge(input int r, input int m, input int l,
                                       input int lv, input int be);
        int  leff;
        bit  on;
        if (r == 0) begin
            m_level = 0; m_prev_mode = 0; m_prev_blink = 0;
            m_sweep_k = 0; m_blink_k = 0; m_out = FULL;
            return;
        end
        leff = lv ? l : m_level;
        if (lv) m_level = l;
        if (m == 4) m_sweep_k = (m_prev_mode == 4) ? m_sweep_k + 1 : 0;
        if (be) m_blink_k = m_prev_blink ? m_blink_k + 1 : 0;
        on = be ? (((m_blink_k / BD) % 2) == 0) : 1'b1;
        if (m <= 5) m_out = on ? pat(m, leff, tri_pos(m_sweep_k / SD)) : 0;
        m_prev_mode = m;
        m_prev_blink = be;
    endfunction

    // Drive one cycle of inputs; expected value comes from the model unless a fixed one is given.
    task automatic drive(input int r, input int m, input int l, input int lv,
                         input int be, input int fixed = -1);
        sb_item_t it;
        @(negedge clk);
        rst = r[0]; mode = m[2:0]; level = l[2:0]; level_valid = lv[0]; blink_en = be[0];
        model_edge(r, m, l, lv, be);
        it.exp = (fixed >= 0) ? fixed : m_out;
        it.seq = seq_no;
        seq_no++;
        sb.push_back(it);
    endtask

    always @(posedge clk) begin
        sb_item_t it;
        #1;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            checks++;
            if (int'(dout) != it.exp) begin
                errors++;
                $display("FAIL %s #%0d: out=%b expected=%b", tag, it.seq, dout, it.exp[N-1:0]);
            end else begin
                $display("ok   %s #%0d: out=%b", tag, it.seq, dout);
            end
        end
    end

    int tbl[3][6] = '{'{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111},
                      '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00001},
                      '{5'b11111, 5'b10111, 5'b10011, 5'b10001, 5'b00000, 5'b00000}};
    int lvls[6] = '{0, 1, 2, 3, 4, 7};
    int sweep_exp[12] = '{1, 1, 2, 2, 4, 4, 8, 8, 16, 16, 8, 8};

    initial begin
        tag = "reset";
        drive(0, 1, 3, 1, 0, FULL);
        drive(0, 1, 3, 1, 0, FULL);
        drive(1, 1, 5, 0, 0, 5'b00001);

        tag = "table";
        for (int m = 1; m <= 3; m++) begin
            for (int i = 0; i < 6; i++) drive(1, m, lvls[i], 1, 0, tbl[m-1][i]);
        end

        tag = "hold";
        drive(1, 1, 2, 1, 0, 5'b00111);
        for (int i = 0; i < 10; i++) drive(1, 1, 4, 0, 0, 5'b00111);
        drive(1, 2, 4, 0, 0, 5'b00100);

        tag = "sweep";
        for (int i = 0; i < 12; i++) drive(1, 4, 0, 0, 0, sweep_exp[i]);
        for (int i = 0; i < 8; i++) drive(1, 4, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0, 5'b00001);
        drive(1, 4, 0, 0, 0, 5'b00001);
        drive(1, 4, 0, 0, 0, 5'b00010);

        tag = "blink";
        for (int i = 0; i < 14; i++) drive(1, 5, 0, 0, 1, ((i / 4) % 2 == 0) ? FULL : 0);
        drive(1, 5, 0, 0, 0, FULL);

        tag = "reserved";
        drive(1, 1, 3, 1, 0, 5'b01111);
        for (int i = 0; i < 3; i++) drive(1, 6 + (i % 2), 0, 0, 0, 5'b01111);

        tag = "rst_mid_sweep";
        for (int i = 0; i < 5; i++) drive(1, 4, 0, 0, 0);
        drive(0, 4, 0, 0, 0, FULL);
        drive(1, 4, 0, 0, 0, 5'b00001);
        drive(1, 4, 0, 0, 0, 5'b00001);
        drive(1, 4, 0, 0, 0, 5'b00010);

        tag = "random";
        for (int i = 0; i < 400; i++) begin
            int m, r, be;
            m  = ($urandom_range(0, 9) < 4) ? 4 : $urandom_range(0, 7);
            r  = ($urandom_range(0, 59) == 0) ? 0 : 1;
            be = ($urandom_range(0, 15) < 9) ? 1 : 0;
            drive(r, m, $urandom_range(0, 7), $urandom_range(0, 1), be);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < $urandom_range(1, 6); k++) drive(r | 1, m, 0, 0, be);
            end
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
